// File: rtl/z80bus_sram_responder_pkg.sv
// Shared state encoding and default SRAM timing for z80 bus responders.
// The wait counter is 3 bits wide, so timing parameters must stay within 1..7.
package z80bus_sram_responder_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WSETUP,
      S_WPULSE,
      S_WHOLD,
      S_ACK,
      S_DONE
   } state_t;

   localparam int CNT_W        = 3;
   localparam int DEF_RD_WAIT  = 2;
   localparam int DEF_WR_SETUP = 1;
   localparam int DEF_WR_WAIT  = 2;

   function automatic logic cnt_last(input logic [CNT_W-1:0] cnt, input int unsigned n);
      return cnt == CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/z80bus_sram_responder.sv
// Bus slave driving an async SRAM; read ack RD_WAIT+1 edges and write ack
// WR_SETUP+WR_WAIT+2 edges after the sampling edge; a held cs stalls in DONE until released.
module z80bus_sram_responder
   import z80bus_sram_responder_pkg::*;
#(
   parameter int unsigned RD_WAIT  = DEF_RD_WAIT,
   parameter int unsigned WR_SETUP = DEF_WR_SETUP,
   parameter int unsigned WR_WAIT  = DEF_WR_WAIT
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_dat,
   output logic [7:0]  o_dat,
   input  logic        i_we,
   input  logic        i_cs,
   output logic        o_ack,
   output logic [15:0] o_sram_addr,
   output logic [7:0]  o_sram_dq,
   output logic        o_sram_dq_oe,
   input  logic [7:0]  i_sram_dq,
   output logic        o_sram_ce_n,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             wr_abort;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wr_abort     <= 1'b0;
         o_ack        <= 1'b0;
         o_dat        <= '0;
         o_sram_addr  <= '0;
         o_sram_dq    <= '0;
         o_sram_dq_oe <= 1'b0;
         o_sram_ce_n  <= 1'b1;
         o_sram_oe_n  <= 1'b1;
         o_sram_we_n  <= 1'b1;
      end else begin
         o_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_cs) begin
                  o_sram_addr <= i_addr;
                  o_sram_dq   <= i_dat;
                  o_sram_ce_n <= 1'b0;
                  cnt         <= '0;
                  wr_abort    <= 1'b0;
                  if (i_we) begin
                     o_sram_dq_oe <= 1'b1;
                     state        <= S_WSETUP;
                  end else begin
                     o_sram_oe_n <= 1'b0;
                     state       <= S_RD;
                  end
               end
            end
            S_RD: begin
               // A dropped cs wins over the capture edge: no data, no ack.
               if (!i_cs) begin
                  o_sram_ce_n <= 1'b1;
                  o_sram_oe_n <= 1'b1;
                  state       <= S_IDLE;
               end else if (cnt_last(cnt, RD_WAIT)) begin
                  o_dat       <= i_sram_dq;
                  o_sram_ce_n <= 1'b1;
                  o_sram_oe_n <= 1'b1;
                  state       <= S_ACK;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            S_WSETUP: begin
               if (!i_cs) begin
                  o_sram_ce_n  <= 1'b1;
                  o_sram_dq_oe <= 1'b0;
                  state        <= S_IDLE;
               end else if (cnt_last(cnt, WR_SETUP)) begin
                  o_sram_we_n <= 1'b0;
                  cnt         <= '0;
                  state       <= S_WPULSE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            S_WPULSE: begin
               // Once WE has fallen the pulse must run to completion to avoid a runt write.
               if (!i_cs) wr_abort <= 1'b1;
               if (cnt_last(cnt, WR_WAIT)) begin
                  o_sram_we_n <= 1'b1;
                  state       <= S_WHOLD;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            S_WHOLD: begin
               o_sram_ce_n  <= 1'b1;
               o_sram_dq_oe <= 1'b0;
               state        <= (wr_abort || !i_cs) ? S_IDLE : S_ACK;
            end
            S_ACK: begin
               o_ack <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               if (!i_cs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80bus_sram_responder.sv
// Directed bench: behavioural SRAM model plus strobe monitors around z80bus_sram_responder.
module tb_z80bus_sram_responder;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [15:0] i_addr = '0;
   logic [7:0]  i_dat = '0;
   logic        i_we = 1'b0;
   logic        i_cs = 1'b0;
   logic [7:0]  o_dat;
   logic        o_ack;
   logic [15:0] o_sram_addr;
   logic [7:0]  o_sram_dq;
   logic        o_sram_dq_oe;
   logic [7:0]  i_sram_dq;
   logic        o_sram_ce_n, o_sram_oe_n, o_sram_we_n;

   logic [7:0] mem [0:65535];
   int total = 0;
   int bad = 0;
   int ack_cnt = 0, acc_cnt = 0, excl_viol = 0, we_viol = 0;
   logic prev_ce = 1'b1, prev_we = 1'b1, prev_dqoe = 1'b0;

   always #5 clk = ~clk;

   z80bus_sram_responder dut (
      .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat),
      .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_sram_addr(o_sram_addr),
      .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe), .i_sram_dq(i_sram_dq),
      .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n)
   );

   assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr] : 8'hEE;

   always @(negedge clk) begin
      if (!o_sram_ce_n && !o_sram_we_n && o_sram_dq_oe) mem[o_sram_addr] = o_sram_dq;
      if (o_ack) ack_cnt++;
      if (prev_ce && !o_sram_ce_n) acc_cnt++;
      if (!o_sram_oe_n && o_sram_dq_oe) excl_viol++;
      if (prev_we && !o_sram_we_n && ((prev_ce && !o_sram_ce_n) || (!prev_dqoe && o_sram_dq_oe)))
         we_viol++;
      prev_ce = o_sram_ce_n;
      prev_we = o_sram_we_n;
      prev_dqoe = o_sram_dq_oe;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Starts at a negedge, returns at a negedge with cs low for one cycle already elapsed.
   task automatic bus_access(input logic we, input logic [15:0] addr, input logic [7:0] dat,
                             input int hold, output int lat, output int oe_c,
                             output int we_c, output int dqoe_c);
      lat = 99; oe_c = 0; we_c = 0; dqoe_c = 0;
      i_addr = addr; i_dat = dat; i_we = we; i_cs = 1'b1;
      for (int n = 1; n <= 20 && lat == 99; n++) begin
         @(negedge clk);
         if (!o_sram_oe_n) oe_c++;
         if (!o_sram_we_n) we_c++;
         if (o_sram_dq_oe) dqoe_c++;
         if (o_ack) lat = n - 1;
      end
      repeat (hold) @(negedge clk);
      i_cs = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat, oe_c, we_c, dqoe_c, a0, k0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h1234] = 8'hA5;
      mem[16'h0042] = 8'h3C;

      repeat (2) @(negedge clk);
      chk("rst_ack", o_ack, 0);
      chk("rst_dat", o_dat, 8'h00);
      chk("rst_ce", o_sram_ce_n, 1);
      chk("rst_oe", o_sram_oe_n, 1);
      chk("rst_we", o_sram_we_n, 1);
      chk("rst_dqoe", o_sram_dq_oe, 0);
      chk("rst_addr", o_sram_addr, 16'h0000);
      i_reset = 1'b0;
      @(negedge clk);

      // 1: read
      bus_access(1'b0, 16'h1234, 8'h00, 0, lat, oe_c, we_c, dqoe_c);
      chk("rd_lat", lat, 3);
      chk("rd_oe_cyc", oe_c, 2);
      chk("rd_dat", o_dat, 8'hA5);

      // 2: write then readback
      bus_access(1'b1, 16'h8000, 8'h5A, 0, lat, oe_c, we_c, dqoe_c);
      chk("wr_lat", lat, 5);
      chk("wr_we_cyc", we_c, 2);
      chk("wr_dqoe_cyc", dqoe_c, 4);
      chk("wr_oe_cyc", oe_c, 0);
      chk("wr_mem", mem[16'h8000], 8'h5A);
      chk("wr_keep_dat", o_dat, 8'hA5);
      bus_access(1'b0, 16'h8000, 8'h00, 0, lat, oe_c, we_c, dqoe_c);
      chk("wr_readback", o_dat, 8'h5A);

      // 3: cs held long after ack
      a0 = acc_cnt; k0 = ack_cnt;
      bus_access(1'b0, 16'h1234, 8'h00, 10, lat, oe_c, we_c, dqoe_c);
      chk("hold_acc", acc_cnt - a0, 1);
      chk("hold_ack", ack_cnt - k0, 1);
      bus_access(1'b0, 16'h0042, 8'h00, 0, lat, oe_c, we_c, dqoe_c);
      chk("hold_next_lat", lat, 3);
      chk("hold_next_dat", o_dat, 8'h3C);

      // 4a: abort during read (cs drops on the capture edge)
      k0 = ack_cnt;
      i_addr = 16'h1234; i_we = 1'b0; i_cs = 1'b1;
      repeat (2) @(negedge clk);
      i_cs = 1'b0;
      repeat (6) @(negedge clk);
      chk("abrt_rd_ack", ack_cnt - k0, 0);
      chk("abrt_rd_dat", o_dat, 8'h3C);
      chk("abrt_rd_ce", o_sram_ce_n, 1);

      // 4b: abort during write pulse
      k0 = ack_cnt; we_c = 0;
      i_addr = 16'h2000; i_dat = 8'h77; i_we = 1'b1; i_cs = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (!o_sram_we_n) we_c++;
         if (n == 2) i_cs = 1'b0;
      end
      chk("abrt_wr_ack", ack_cnt - k0, 0);
      chk("abrt_wr_pulse", we_c, 2);
      chk("abrt_wr_mem", mem[16'h2000], 8'h77);
      chk("abrt_wr_dqoe", o_sram_dq_oe, 0);

      // 4c: abort during write setup leaves memory untouched
      i_addr = 16'h2100; i_dat = 8'h11; i_we = 1'b1; i_cs = 1'b1;
      @(negedge clk);
      i_cs = 1'b0;
      repeat (5) @(negedge clk);
      chk("abrt_ws_mem", mem[16'h2100], 8'h00);

      // 5: async reset in the middle of a write pulse
      i_addr = 16'h3000; i_dat = 8'h99; i_we = 1'b1; i_cs = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_we", o_sram_we_n, 0);
      i_reset = 1'b1;
      #1;
      chk("arst_we", o_sram_we_n, 1);
      chk("arst_ce", o_sram_ce_n, 1);
      chk("arst_dqoe", o_sram_dq_oe, 0);
      chk("arst_dat", o_dat, 8'h00);
      chk("arst_addr", o_sram_addr, 16'h0000);
      chk("arst_dq", o_sram_dq, 8'h00);
      @(negedge clk);
      i_cs = 1'b0;
      i_reset = 1'b0;
      @(negedge clk);

      // 6: back-to-back read / write / read
      bus_access(1'b0, 16'h8000, 8'h00, 0, lat, oe_c, we_c, dqoe_c);
      chk("b2b_rd1", o_dat, 8'h5A);
      bus_access(1'b1, 16'h1234, 8'hC3, 0, lat, oe_c, we_c, dqoe_c);
      chk("b2b_wr_lat", lat, 5);
      bus_access(1'b0, 16'h1234, 8'h00, 0, lat, oe_c, we_c, dqoe_c);
      chk("b2b_rd2", o_dat, 8'hC3);
      chk("b2b_rd2_lat", lat, 3);

      chk("oe_dqoe_excl", excl_viol, 0);
      chk("we_fall_order", we_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
